// File: rtl/game_flow_ctrl.sv
// Game-flow controller: debounces BTNC and sequences MENU/PLAY/OVER/WIN, issues the
// game-core start pulse and keeps the high score for the 7-segment path.
module game_flow_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned SCORE_W         = 9
) (
  input  logic               CLK,
  input  logic               RST_BTN,
  input  logic               BTNC,
  input  logic               endgame,
  input  logic               win_game,
  input  logic [SCORE_W-1:0] curr_score,
  output logic [1:0]         screen_sel,
  output logic               game_run,
  output logic               game_start,
  output logic [SCORE_W-1:0] highest_score,
  output logic               new_high
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    StMenu = 2'b00,
    StPlay = 2'b01,
    StOver = 2'b10,
    StWin  = 2'b11
  } state_e;

  // BTNC synchroniser and debouncer
  logic [1:0]      sync_q;
  logic            btn_synced;
  logic            stable_q, stable_d;
  logic            stable_prev_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            press;

  assign btn_synced = sync_q[1];

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (btn_synced != stable_q) begin
      if (cnt_q == CntMax) begin
        stable_d = ~stable_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  // Rising edge of the debounced level only; release is ignored.
  assign press = stable_q & ~stable_prev_q;

  always_ff @(posedge CLK) begin
    if (RST_BTN) begin
      sync_q        <= 2'b00;
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      sync_q        <= {sync_q[0], BTNC};
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      cnt_q         <= cnt_d;
    end
  end

  // Flow FSM with registered outputs
  state_e             state_q, state_d;
  logic               game_run_q, game_run_d;
  logic               game_start_q, game_start_d;
  logic               new_high_q, new_high_d;
  logic [SCORE_W-1:0] high_q, high_d;

  always_comb begin
    state_d      = state_q;
    game_start_d = 1'b0;
    new_high_d   = new_high_q;
    high_d       = high_q;
    unique case (state_q)
      StMenu: begin
        if (press) begin
          state_d      = StPlay;
          game_start_d = 1'b1;
        end
      end
      StPlay: begin
        if (win_game || endgame) begin
          state_d = win_game ? StWin : StOver;
          // Strictly greater: tying the record is not a new high.
          if (curr_score > high_q) begin
            high_d     = curr_score;
            new_high_d = 1'b1;
          end
        end
      end
      StOver, StWin: begin
        if (press) begin
          state_d    = StMenu;
          new_high_d = 1'b0;
        end
      end
      default: state_d = StMenu;
    endcase
    game_run_d = (state_d == StPlay);
  end

  always_ff @(posedge CLK) begin
    if (RST_BTN) begin
      state_q      <= StMenu;
      game_run_q   <= 1'b0;
      game_start_q <= 1'b0;
      new_high_q   <= 1'b0;
      high_q       <= '0;
    end else begin
      state_q      <= state_d;
      game_run_q   <= game_run_d;
      game_start_q <= game_start_d;
      new_high_q   <= new_high_d;
      high_q       <= high_d;
    end
  end

  assign screen_sel    = state_q;
  assign game_run      = game_run_q;
  assign game_start    = game_start_q;
  assign new_high      = new_high_q;
  assign highest_score = high_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed self-checking bench for game_flow_ctrl with a short debounce window.
module tb_game_flow_ctrl;

  localparam int unsigned DC = 4;
  localparam int unsigned SW = 9;

  logic          CLK = 1'b0;
  logic          RST_BTN, BTNC, endgame, win_game;
  logic [SW-1:0] curr_score;
  logic [1:0]    screen_sel;
  logic          game_run, game_start, new_high;
  logic [SW-1:0] highest_score;

  int n_cmp = 0;
  int n_err = 0;

  game_flow_ctrl #(
    .DEBOUNCE_CYCLES(DC),
    .SCORE_W        (SW)
  ) dut (
    .CLK          (CLK),
    .RST_BTN      (RST_BTN),
    .BTNC         (BTNC),
    .endgame      (endgame),
    .win_game     (win_game),
    .curr_score   (curr_score),
    .screen_sel   (screen_sel),
    .game_run     (game_run),
    .game_start   (game_start),
    .highest_score(highest_score),
    .new_high     (new_high)
  );

  always #5 CLK = ~CLK;

  // Advance one edge and settle away from it.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Full press: 7 edges high (consumed on the 7th), then a clean release.
  task automatic press_btn();
    BTNC = 1'b1;
    tick(7);
    BTNC = 1'b0;
    tick(8);
  endtask

  task automatic do_reset();
    RST_BTN = 1'b1;
    tick(2);
    RST_BTN = 1'b0;
  endtask

  initial begin
    RST_BTN    = 1'b1;
    BTNC       = 1'b0;
    endgame    = 1'b0;
    win_game   = 1'b0;
    curr_score = '0;
    do_reset();

    check("rst_screen", 32'(screen_sel), 0);
    check("rst_run", 32'(game_run), 0);
    check("rst_start", 32'(game_start), 0);
    check("rst_high", 32'(highest_score), 0);
    check("rst_new_high", 32'(new_high), 0);
    check("rst_cnt", 32'(dut.cnt_q), 0);
    check("rst_stable", 32'(dut.stable_q), 0);

    // Glitch of 3 cycles must not register.
    BTNC = 1'b1;
    tick(3);
    BTNC = 1'b0;
    tick(5);
    check("glitch_screen", 32'(screen_sel), 0);
    check("glitch_cnt", 32'(dut.cnt_q), 0);
    check("glitch_stable", 32'(dut.stable_q), 0);

    // Clean press: nothing after 6 edges, PLAY on the 7th.
    BTNC = 1'b1;
    tick(6);
    check("press_early_screen", 32'(screen_sel), 0);
    check("press_early_start", 32'(game_start), 0);
    tick(1);
    check("press_screen", 32'(screen_sel), 1);
    check("press_start", 32'(game_start), 1);
    check("press_run", 32'(game_run), 1);
    tick(1);
    check("start_one_cycle", 32'(game_start), 0);
    check("play_held", 32'(screen_sel), 1);
    tick(2);
    BTNC = 1'b0;
    tick(8);
    check("release_no_effect", 32'(screen_sel), 1);

    // Press during PLAY is ignored.
    press_btn();
    check("play_press_ignored", 32'(screen_sel), 1);
    check("play_press_no_start", 32'(game_start), 0);

    // Game 1: score 37 ends -> new record.
    curr_score = 9'd37;
    endgame    = 1'b1;
    tick(1);
    endgame = 1'b0;
    check("g1_screen", 32'(screen_sel), 2);
    check("g1_high", 32'(highest_score), 37);
    check("g1_new_high", 32'(new_high), 1);
    check("g1_run", 32'(game_run), 0);
    press_btn();
    check("g1_menu", 32'(screen_sel), 0);
    check("g1_nh_clear", 32'(new_high), 0);
    check("g1_high_held", 32'(highest_score), 37);

    // Game 2: score 20 is lower.
    press_btn();
    check("g2_play", 32'(screen_sel), 1);
    curr_score = 9'd20;
    endgame    = 1'b1;
    tick(1);
    endgame = 1'b0;
    check("g2_screen", 32'(screen_sel), 2);
    check("g2_high", 32'(highest_score), 37);
    check("g2_new_high", 32'(new_high), 0);
    press_btn();

    // Game 3: tie at 37 via win is not a record; endgame ignored in WIN.
    press_btn();
    curr_score = 9'd37;
    win_game   = 1'b1;
    tick(1);
    win_game = 1'b0;
    check("g3_screen", 32'(screen_sel), 3);
    check("g3_high", 32'(highest_score), 37);
    check("g3_new_high", 32'(new_high), 0);
    endgame = 1'b1;
    tick(1);
    endgame = 1'b0;
    check("g3_win_holds", 32'(screen_sel), 3);
    press_btn();
    check("g3_menu", 32'(screen_sel), 0);

    // Game 4: both flags together, win has priority; max score.
    press_btn();
    curr_score = 9'd511;
    endgame    = 1'b1;
    win_game   = 1'b1;
    tick(1);
    endgame  = 1'b0;
    win_game = 1'b0;
    check("g4_screen", 32'(screen_sel), 3);
    check("g4_high", 32'(highest_score), 511);
    check("g4_new_high", 32'(new_high), 1);
    press_btn();

    // Reset mid-game with high score 37.
    do_reset();
    press_btn();
    curr_score = 9'd37;
    endgame    = 1'b1;
    tick(1);
    endgame = 1'b0;
    press_btn();
    press_btn();
    check("pre_rst_play", 32'(screen_sel), 1);
    check("pre_rst_high", 32'(highest_score), 37);
    RST_BTN = 1'b1;
    tick(1);
    RST_BTN = 1'b0;
    check("mid_rst_screen", 32'(screen_sel), 0);
    check("mid_rst_high", 32'(highest_score), 0);
    check("mid_rst_run", 32'(game_run), 0);
    check("mid_rst_start", 32'(game_start), 0);
    tick(1);
    check("post_rst_start", 32'(game_start), 0);
    check("post_rst_screen", 32'(screen_sel), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
